fma_norm_round: RTL and testbench

Pipelined normalize-and-round back end for the FP32 fused multiply-add datapath. It sits directly downstream of the 73-bit aligned add/sub stage and converts the raw signed-magnitude sum into a packed IEEE-754 binary32 result with round-to-nearest-even and exception flags. Three register stages, full throughput, valid/ready handshake on both sides.

---
 rtl/fma_pkg.sv | 28 ++
 rtl/fma_norm_round_if.sv | 27 ++
 rtl/fma_norm_round_lzc.sv | 20 ++
 rtl/fma_norm_round.sv | 165 ++++++++++++++++
 tb/tb_fma_norm_round.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fma_pkg.sv
// Shared widths and beat types for the FP32 FMA normalize/round back end.
package fma_pkg;

    localparam int MAG_W  = 73;   // aligned add/sub magnitude width
    localparam int EXP_W  = 10;   // signed input exponent width
    localparam int BIAS   = 127;  // binary32 exponent bias
    localparam int FRAC_W = 23;   // binary32 fraction width
    localparam int POS_W  = 7;    // leading-one index width (0..72)
    localparam int SE_W   = 11;   // signed biased exponent width inside the pipe

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } fma_flags_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAG_W-1:0] mag;
    } norm_beat_t;

    // Round-to-nearest-even: bump only above half, or at half with an odd lsb.
    function automatic logic rne_inc(input logic lsb, input logic guard, input logic sticky);
        return guard & (sticky | lsb);
    endfunction

endpackage

// File: rtl/fma_norm_round_if.sv
// Input/output handshake bundle of the normalize/round back end.
interface fma_norm_round_if;
    import fma_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic [MAG_W-1:0] in_mag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [2:0]       out_flags;

    // Block side.
    modport slave (
        input  in_valid, in_sign, in_exp, in_mag, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_sign, in_exp, in_mag, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

endinterface

// File: rtl/fma_norm_round_lzc.sv
// Leading-one locator for the 73-bit sum magnitude.
module lzc_73
    import fma_pkg::*;
(
    input  logic [MAG_W-1:0] mag,
    output logic [POS_W-1:0] pos,
    output logic             zero
);

    // Highest set bit wins; an all-zero input reports position 0.
    always_comb begin
        pos = '0;
        for (int i = 0; i < MAG_W; i++) begin
            if (mag[i]) pos = POS_W'(i);
        end
    end

    assign zero = ~|mag;

endmodule

// File: rtl/fma_norm_round.sv
// Three-stage normalize and RNE-round of the FMA sum into packed binary32.
// S1 locates the leading one, S2 aligns (including denormalization), S3
// rounds, detects overflow and packs. Each stage holds when its successor
// is full and stalled, so bubbles collapse and throughput is one per cycle.
module fma_norm_round
    import fma_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    fma_norm_round_if.slave bus
);

    // e = in_exp + (p - 46) + BIAS, folded into a single constant.
    localparam logic signed [SE_W-1:0] E_OFS = SE_W'(BIAS - 46);

    // ---------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------
    logic v1, v2, v3;
    logic rdy1, rdy2, rdy3;

    assign rdy3          = !v3 || bus.out_ready;
    assign rdy2          = !v2 || rdy3;
    assign rdy1          = !v1 || rdy2;
    assign bus.in_ready  = rdy1;
    assign bus.out_valid = v3;

    // ---------------------------------------------------------------
    // Stage 1: capture beat with its leading-one index
    // ---------------------------------------------------------------
    norm_beat_t       s1_beat;
    logic [POS_W-1:0] s1_pos;
    logic             s1_zero;
    logic [POS_W-1:0] lzc_pos;
    logic             lzc_zero;

    lzc_73 u_lzc (
        .mag  (bus.in_mag),
        .pos  (lzc_pos),
        .zero (lzc_zero)
    );

    // S1 register: valid under async reset, data loads only on a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (rdy1) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                s1_beat <= {bus.in_sign, bus.in_exp, bus.in_mag};
                s1_pos  <= lzc_pos;
                s1_zero <= lzc_zero;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: biased exponent, normalize, denormalize tiny results
    // ---------------------------------------------------------------
    logic signed [SE_W-1:0] e_c;
    logic signed [SE_W-1:0] sh_full;
    logic                   sub;
    logic                   flush;
    logic [4:0]             sh;
    logic [MAG_W-1:0]       norm;
    logic [96:0]            ext;      // 23 frac + guard + 73 sticky-source bits
    logic [FRAC_W-1:0]      frac_c;
    logic                   grd_c;
    logic                   stk_c;

    // Leading one is moved to bit 72; the hidden bit then falls off the top
    // of ext for normals, while subnormal shifts pull it into the fraction.
    // The extra 25 zero bits keep every shifted-out bit visible to sticky.
    always_comb begin
        e_c     = $signed({s1_beat.exp[EXP_W-1], s1_beat.exp})
                + $signed({4'd0, s1_pos}) + E_OFS;
        sub     = (e_c < 11'sd1);
        sh_full = 11'sd1 - e_c;
        flush   = sub && (sh_full > 11'sd25);
        sh      = sub ? sh_full[4:0] : 5'd0;
        norm    = s1_beat.mag << (7'd72 - s1_pos);
        ext     = 97'({norm, 25'b0} >> sh);
        frac_c  = flush ? '0   : ext[96:74];
        grd_c   = flush ? 1'b0 : ext[73];
        stk_c   = flush ? 1'b1 : |ext[72:0];
    end

    logic              s2_sign;
    logic              s2_zero;
    logic              s2_tiny;
    logic [SE_W-1:0]   s2_exp;
    logic [FRAC_W-1:0] s2_frac;
    logic              s2_grd;
    logic              s2_stk;

    // S2 register: aligned fraction with guard/sticky and pre-round tininess.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
        end else if (rdy2) begin
            v2 <= v1;
            if (v1) begin
                s2_sign <= s1_beat.sign;
                s2_zero <= s1_zero;
                s2_tiny <= sub;
                s2_exp  <= sub ? '0 : $unsigned(e_c);
                s2_frac <= frac_c;
                s2_grd  <= grd_c;
                s2_stk  <= stk_c;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 3: round, overflow, pack
    // ---------------------------------------------------------------
    logic                     inc;
    logic [SE_W+FRAC_W-1:0]   sum;
    logic [SE_W-1:0]          exp_f;
    logic                     ovf;
    logic                     inx;
    logic [31:0]              res_c;
    fma_flags_t               flg_c;

    // Rounding adds into {exp, frac} so a fraction carry bumps the exponent;
    // a subnormal 0x7FFFFF rounding up lands on exponent 1 the same way.
    always_comb begin
        inc   = rne_inc(s2_frac[0], s2_grd, s2_stk);
        sum   = {s2_exp, s2_frac} + {{(SE_W+FRAC_W-1){1'b0}}, inc};
        exp_f = sum[SE_W+FRAC_W-1:FRAC_W];
        ovf   = (exp_f >= 11'd255);
        inx   = s2_grd | s2_stk;
        res_c = {s2_sign, exp_f[7:0], sum[FRAC_W-1:0]};
        flg_c = {1'b0, s2_tiny & inx, inx};
        if (s2_zero) begin
            res_c = {s2_sign, 31'd0};
            flg_c = '0;
        end else if (ovf) begin
            res_c = {s2_sign, 8'hFF, 23'd0};
            flg_c = {1'b1, 1'b0, 1'b1};
        end
    end

    logic [31:0] out_result_q;
    fma_flags_t  out_flags_q;

    // S3 / output register: reset to zero, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3           <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else if (rdy3) begin
            v3 <= v2;
            if (v2) begin
                out_result_q <= res_c;
                out_flags_q  <= flg_c;
            end
        end
    end

    assign bus.out_result = out_result_q;
    assign bus.out_flags  = out_flags_q;

endmodule

// File: tb/tb_fma_norm_round.sv
// Directed + randomized bench for fma_norm_round with a value-level model.
module tb_fma_norm_round;

    logic clk = 1'b0;
    logic rst;

    fma_norm_round_if bus ();

    fma_norm_round dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [34:0] exp_q[$];   // {result, flags} in issue order
    bit         rnd_done;

    // Reference: value = mag * 2^(ex-46). Pick the ulp of the target format,
    // divide, round to nearest even on the remainder, then encode the result.
    function automatic logic [34:0] ref_model(input logic sgn, input int ex, input logic [72:0] mag);
        logic [127:0] m, n, rem, half;
        int p, e_unb, qexp, k, s, msb, t, biased;
        logic inex, up, tiny;
        logic [31:0] res;
        if (mag == '0) return {sgn, 31'd0, 3'b000};
        p = 0;
        for (int i = 0; i < 73; i++) if (mag[i]) p = i;
        e_unb = ex + p - 46;
        tiny  = (e_unb < -126);
        qexp  = (tiny ? -126 : e_unb) - 23;
        k     = ex - 46 - qexp;
        m     = 128'(mag);
        inex  = 1'b0;
        up    = 1'b0;
        if (k >= 0) begin
            n = m << k;
        end else begin
            s = -k;
            if (s >= 100) begin
                n    = '0;
                inex = 1'b1;
            end else begin
                n    = m >> s;
                rem  = m - (n << s);
                half = 128'd1 << (s - 1);
                inex = (rem != 0);
                up   = (rem > half) || ((rem == half) && n[0]);
            end
        end
        n = n + 128'(up);
        msb = -1;
        for (int i = 0; i < 128; i++) if (n[i]) msb = i;
        if (msb < 0) begin
            res = {sgn, 31'd0};
        end else begin
            t = qexp + msb;
            if (t < -126) begin
                res = {sgn, 8'd0, n[22:0]};
            end else begin
                biased = t + 127;
                if (biased >= 255) return {sgn, 8'hFF, 23'd0, 3'b101};
                n   = n >> (msb - 23);
                res = {sgn, 8'(biased), n[22:0]};
            end
        end
        return {res, 1'b0, tiny & inex, inex};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Present one beat, hold until accepted, record its expected result.
    task automatic send(input logic s, input logic [9:0] e, input logic [72:0] m);
        int t;
        t = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_mag   = m;
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("accept", 64'(bus.in_ready), 64'd1);
        exp_q.push_back(ref_model(s, int'($signed(e)), m));
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Send into an idle, unstalled pipe and confirm the 3-cycle latency.
    task automatic lat_check(input logic s, input logic [9:0] e, input logic [72:0] m);
        send(s, e, m);
        @(negedge clk); chk("lat_c1", 64'(bus.out_valid), 64'd0);
        @(negedge clk); chk("lat_c2", 64'(bus.out_valid), 64'd0);
        @(negedge clk); chk("lat_c3", 64'(bus.out_valid), 64'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: the presented output must match the oldest expected beat
    // on every cycle it is valid, including while stalled.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'(bus.out_valid), 64'd0);
            end else begin
                chk("result", 64'(bus.out_result), 64'(exp_q[0][34:3]));
                chk("flags", 64'(bus.out_flags), 64'(exp_q[0][2:0]));
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [95:0] r;
        logic [72:0] mg;
        logic [9:0]  ex;
        int          w;
        int          band;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mag    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_result", 64'(bus.out_result), 64'd0);
        chk("rst_flags", 64'(bus.out_flags), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed values from the test plan.
        lat_check(1'b0, 10'd0, 73'd1 << 46);
        chk("one_result", 64'(bus.out_result), 64'h3F800000);
        send(1'b1, 10'd0,   73'd1 << 46);
        send(1'b0, 10'd0,   (73'd1 << 46) | (73'd1 << 22));
        send(1'b0, 10'd0,   (73'd1 << 46) | (73'd1 << 23) | (73'd1 << 22));
        send(1'b0, 10'd128, 73'd1 << 46);
        send(1'b1, 10'd0,   73'd0);
        send(1'b0, 10'(-149), 73'd1 << 46);
        send(1'b0, 10'(-150), (73'd1 << 46) | 73'd1);
        send(1'b0, 10'(-127), 73'h1FFFFFF << 22);
        drain();

        // Backpressure: six beats against a consumer stalled for five cycles.
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) send(i[0], 10'(i), (73'd1 << 46) | 73'(i + 1));
                @(negedge clk);
                chk("full_in_ready", 64'(bus.in_ready), 64'd0);
                for (int i = 3; i < 6; i++) send(i[0], 10'(i), (73'd1 << 46) | 73'(i + 1));
            end
            begin
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight.
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        send(1'b0, 10'd5, (73'd1 << 50) | 73'd7);
        send(1'b1, 10'd9, (73'd1 << 40) | 73'd3);
        @(posedge clk);
        #1 chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("arst_result", 64'(bus.out_result), 64'd0);
        chk("arst_flags", 64'(bus.out_flags), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("no_stale", 64'(bus.out_valid), 64'd0);
        end
        lat_check(1'b1, 10'(-3), (73'd1 << 60) | 73'd12345);
        drain();

        // Randomized traffic across normal, subnormal and overflow ranges.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    r    = {$urandom, $urandom, $urandom};
                    w    = $urandom_range(1, 73);
                    mg   = 73'(r) >> (73 - w);
                    if ($urandom_range(19) == 0) mg = '0;
                    band = $urandom_range(3);
                    case (band)
                        0:       ex = 10'(int'($urandom_range(200)) - 100);
                        1:       ex = 10'(int'($urandom_range(80)) - 200);
                        2:       ex = 10'(int'($urandom_range(60)) + 90);
                        default: ex = 10'($urandom);
                    endcase
                    send(1'($urandom), ex, mg);
                    if ($urandom_range(3) == 0) @(posedge clk);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(3) != 0);
                end
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
